// File: rtl/adc_sample_scheduler_if.sv
// rtl/adc_sample_scheduler_if.sv - ADC reader handshake and framed sample stream bundle
interface adc_sample_scheduler_if;
    logic        o_ADC_Data_Requested;
    logic        i_ADC_Data_Valid;
    logic [11:0] i_ADC_Data;
    logic [11:0] o_Sample_Data;
    logic        o_Sample_Last;
    logic        o_Sample_Valid;
    logic        i_Sample_Ready;

    modport master (
        output o_ADC_Data_Requested,
        input  i_ADC_Data_Valid,
        input  i_ADC_Data,
        output o_Sample_Data,
        output o_Sample_Last,
        output o_Sample_Valid,
        input  i_Sample_Ready
    );

    modport slave (
        input  o_ADC_Data_Requested,
        output i_ADC_Data_Valid,
        output i_ADC_Data,
        input  o_Sample_Data,
        input  o_Sample_Last,
        input  o_Sample_Valid,
        output i_Sample_Ready
    );
endinterface

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - periodic ADC conversion sequencer with framed FWFT output FIFO
module adc_sample_scheduler #(
    parameter int FRAME_LEN    = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CLKS = 1024,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Enable,
    input  logic [PERIOD_WIDTH-1:0] i_Period,
    input  logic                    i_Clear_Status,
    adc_sample_scheduler_if.master  io_bus,
    output logic                    o_Busy,
    output logic                    o_Missed_Tick,
    output logic                    o_Overrun,
    output logic                    o_Timeout
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT_DATA,
        S_GUARD1,
        S_GUARD2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [PERIOD_WIDTH-1:0] r_count;
    logic                    r_enable_d;
    logic [IW-1:0]           r_index;
    logic [TW-1:0]           r_tmo;
    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic [12:0]             r_mem [FIFO_DEPTH];
    logic                    r_req;
    logic                    r_missed;
    logic                    r_overrun;
    logic                    r_timeout;

    logic        w_tick;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_drop;
    logic        w_tmo_hit;
    logic        w_last;
    logic        w_enable_rise;
    logic [12:0] w_head;

    assign w_tick        = i_Enable && (r_count == '0);
    assign w_enable_rise = i_Enable && !r_enable_d;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = !w_empty && io_bus.i_Sample_Ready;
    assign w_push_req = (r_state == S_WAIT_DATA) && io_bus.i_ADC_Data_Valid;
    // A full FIFO still takes the sample when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;
    assign w_tmo_hit  = (r_state == S_WAIT_DATA) && !io_bus.i_ADC_Data_Valid &&
                        (r_tmo == TW'(TIMEOUT_CLKS - 1));
    assign w_last     = (r_index == IW'(FRAME_LEN - 1));
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_count    <= '0;
            r_enable_d <= 1'b0;
        end else begin
            r_enable_d <= i_Enable;
            if (!i_Enable || (r_count == i_Period)) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == S_REQUEST);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_tick) w_next = S_REQUEST;
            S_REQUEST:   w_next = S_WAIT_DATA;
            S_WAIT_DATA: if (io_bus.i_ADC_Data_Valid || w_tmo_hit) w_next = S_GUARD1;
            // Two idle cycles let the reader finish its cleanup before the next request.
            S_GUARD1:    w_next = S_GUARD2;
            S_GUARD2:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_tmo <= '0;
        end else if (r_state == S_REQUEST) begin
            r_tmo <= '0;
        end else if (r_state == S_WAIT_DATA) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_index <= '0;
        end else if (w_enable_rise) begin
            r_index <= '0;
        end else if (w_push) begin
            r_index <= w_last ? '0 : r_index + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {w_last, io_bus.i_ADC_Data};
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_missed  <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_missed  <= (r_missed  && !i_Clear_Status) || (w_tick && (r_state != S_IDLE));
            r_overrun <= (r_overrun && !i_Clear_Status) || w_drop;
            r_timeout <= (r_timeout && !i_Clear_Status) || w_tmo_hit;
        end
    end

    assign io_bus.o_ADC_Data_Requested = r_req;
    assign io_bus.o_Sample_Data        = w_head[11:0];
    assign io_bus.o_Sample_Last        = w_head[12];
    assign io_bus.o_Sample_Valid       = !w_empty;
    assign o_Busy                      = (r_state != S_IDLE);
    assign o_Missed_Tick               = r_missed;
    assign o_Overrun                   = r_overrun;
    assign o_Timeout                   = r_timeout;
endmodule
